// File: rtl/alu_controller_if.sv
// ALU controller bus: request/instruction inputs, ALU return path and the
// controller's registered outputs. The Zero flag exists only when
// ALU_CONTROLLER_ZERO_FLAG_EN is defined.
interface alu_controller_if;
    logic       start;        // request to execute one instruction
    logic [2:0] instr;        // requested opcode
    logic [4:0] operand;      // requested data operand
    logic [4:0] alu_result;   // combinational result returned by the ALU
    logic [2:0] alu_op;       // opcode driven to the ALU
    logic [4:0] alu_data_in;  // registered operand driven to the ALU
    logic [4:0] r0_out;       // accumulator R0
    logic [1:0] count;        // completed-instruction counter
    logic       busy;         // high in EXEC and DONE
    logic       done;         // one-cycle completion pulse
`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
    logic       zero;         // R0 == 0, registered alongside R0
`endif

    // Requester / ALU side: issues instructions and returns the ALU result.
    modport master (
        output start, instr, operand, alu_result,
        input  alu_op, alu_data_in, r0_out, count, busy, done
`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
        , input zero
`endif
    );

    // Controller side.
    modport slave (
        input  start, instr, operand, alu_result,
        output alu_op, alu_data_in, r0_out, count, busy, done
`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
        , output zero
`endif
    );
endinterface

// File: rtl/alu_controller.sv
// ALU controller: sequences one instruction at a time through a three-state
// FSM (IDLE -> EXEC -> DONE -> IDLE). An accepted request captures opcode and
// operand, the ALU result is written into accumulator R0 at the end of EXEC,
// and a completion counter (mod 4) advances on the same edge.
// Optional feature macro: ALU_CONTROLLER_ZERO_FLAG_EN adds a registered
// R0 == 0 flag on the bus; without it the flag and its logic are absent.
module alu_controller (
    input  logic            clk_i,
    input  logic            rst_i,
    alu_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcode presented to the ALU whenever no instruction is executing, so
    // the ALU simply reflects R0.
    localparam logic [2:0] OP_PASS = 3'b011;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [4:0] operand_q, operand_d;
    logic [4:0] r0_q, r0_d;
    logic [1:0] count_q, count_d;
`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
    logic       zero_q, zero_d;
`endif

    logic accept;   // request taken at the coming edge
    logic retire;   // instruction completes at the coming edge

    assign accept = (state_q == IDLE) && bus.start;
    assign retire = (state_q == EXEC);

    // State register; reset overrides any transition.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: EXEC and DONE each last exactly one cycle, and a
    // Start seen outside IDLE is dropped rather than queued.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_d unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = EXEC;
            EXEC:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the captured opcode reaches the ALU only during EXEC.
    always_comb begin
        bus.alu_op = OP_PASS;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state_q)
            EXEC: begin
                bus.alu_op = op_q;
                bus.busy   = 1'b1;
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next values: capture on accept, write R0 and count on retire.
    always_comb begin
        op_d      = op_q;
        operand_d = operand_q;
        r0_d      = r0_q;
        count_d   = count_q;
        if (accept) begin
            op_d      = bus.instr;
            operand_d = bus.operand;
        end
        if (retire) begin
            // ALU result is taken as-is; count wraps naturally at 2 bits.
            r0_d    = bus.alu_result;
            count_d = count_q + 2'd1;
        end
    end

`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
    // Zero flag tracks the value written into R0 on the same edge.
    always_comb begin
        zero_d = zero_q;
        if (retire) begin
            zero_d = (bus.alu_result == 5'd0);
        end
    end
`endif

    // Datapath registers; reset also aborts an instruction caught in EXEC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q      <= OP_PASS;
            operand_q <= 5'd0;
            r0_q      <= 5'd0;
            count_q   <= 2'd0;
`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
            zero_q    <= 1'b1;
`endif
        end else begin
            op_q      <= op_d;
            operand_q <= operand_d;
            r0_q      <= r0_d;
            count_q   <= count_d;
`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
            zero_q    <= zero_d;
`endif
        end
    end

    // Registered values drive the bus directly; the operand holds between
    // instructions.
    assign bus.alu_data_in = operand_q;
    assign bus.r0_out      = r0_q;
    assign bus.count       = count_q;
`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
    assign bus.zero        = zero_q;
`endif

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller: reset checks, a directed vector
// table, multi-cycle corner sequences and randomized instructions against a
// behavioural model of R0 and the completion count.
module tb_alu_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_controller_if bus();

    alu_controller dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: accumulator and number of completed instructions.
    int m_r0    = 0;
    int m_count = 0;

    // ALU behaviour in plain integer arithmetic, modulo 32.
    function automatic int alu_eval(input int op, input int d, input int r0, input int cnt);
        case (op)
            0:       return cnt % 4;
            1:       return r0 | d;
            2:       return d;
            3:       return r0;
            4:       return (r0 + d) % 32;
            5:       return (r0 - d + 32) % 32;
            6:       return r0 & d;
            default: return r0 ^ d;
        endcase
    endfunction

    // The ALU seen by the controller.
    assign bus.alu_result = 5'(alu_eval(int'(bus.alu_op), int'(bus.alu_data_in),
                                        int'(bus.r0_out), int'(bus.count)));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int r0);
`ifdef ALU_CONTROLLER_ZERO_FLAG_EN
        check("zero", 32'(bus.zero), 32'(r0 == 0));
`else
        if (r0 < 0) $display("unexpected negative model value");
`endif
    endtask

    // Issue one instruction from IDLE and check every cycle of it. With
    // noise set, Start stays high and Instr/Operand change during EXEC/DONE.
    task automatic issue(input logic [2:0] op, input logic [4:0] d,
                         input int exp_r0, input int exp_cnt, input bit noise);
        int prev_r0;
        prev_r0 = int'(bus.r0_out);
        bus.start   = 1'b1;
        bus.instr   = op;
        bus.operand = d;
        step();
        check("exec_busy", 32'(bus.busy), 32'd1);
        check("exec_done", 32'(bus.done), 32'd0);
        check("exec_alu_op", 32'(bus.alu_op), 32'(op));
        check("exec_data_in", 32'(bus.alu_data_in), 32'(d));
        check("exec_count_pre", 32'(bus.count), 32'((exp_cnt + 3) % 4));
        check("exec_r0_hold", 32'(bus.r0_out), 32'(prev_r0));
        if (noise) begin
            bus.instr   = 3'b111;
            bus.operand = 5'($urandom_range(0, 31));
        end else begin
            bus.start = 1'b0;
        end
        step();
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_r0", 32'(bus.r0_out), 32'(exp_r0));
        check("done_count", 32'(bus.count), 32'(exp_cnt));
        check("done_alu_op", 32'(bus.alu_op), 32'd3);
        check_zero(exp_r0);
        step();
        bus.start = 1'b0;
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_alu_op", 32'(bus.alu_op), 32'd3);
        check("idle_data_hold", 32'(bus.alu_data_in), 32'(d));
        check("idle_r0", 32'(bus.r0_out), 32'(exp_r0));
    endtask

    typedef struct {
        logic [2:0] instr;
        logic [4:0] operand;
        int         exp_r0;
        int         exp_count;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int dones;
        int op, d, exp;

        vecs[0] = '{3'b010, 5'd5, 5, 1};
        vecs[1] = '{3'b100, 5'd3, 8, 2};
        vecs[2] = '{3'b101, 5'd8, 0, 3};
        vecs[3] = '{3'b000, 5'd9, 3, 0};
        vecs[4] = '{3'b000, 5'd0, 0, 1};

        bus.start   = 1'b0;
        bus.instr   = 3'b000;
        bus.operand = 5'd0;

        // Reset held two cycles with Start low.
        rst = 1'b1;
        step();
        step();
        check("rst_alu_op", 32'(bus.alu_op), 32'd3);
        check("rst_data_in", 32'(bus.alu_data_in), 32'd0);
        check("rst_r0", 32'(bus.r0_out), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check_zero(0);
        rst = 1'b0;
        step();
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        // Directed vector table.
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].instr, vecs[i].operand, vecs[i].exp_r0, vecs[i].exp_count, 1'b0);
        end
        m_r0    = 0;
        m_count = 1;

        // Start held high for nine cycles: accepted on every IDLE cycle.
        dones = 0;
        bus.start   = 1'b1;
        bus.instr   = 3'b100;
        bus.operand = 5'd1;
        for (int i = 0; i < 9; i++) begin
            step();
            check("held_done", 32'(bus.done), 32'(i % 3 == 1));
            if (bus.done === 1'b1) dones++;
        end
        bus.start = 1'b0;
        check("held_done_total", 32'(dones), 32'd3);
        m_r0    = (m_r0 + 3) % 32;
        m_count = (m_count + 3) % 4;
        check("held_r0", 32'(bus.r0_out), 32'(m_r0));
        check("held_count", 32'(bus.count), 32'(m_count));
        step();
        check("held_idle", 32'(bus.busy), 32'd0);

        // Start pulses with Instr=111 during EXEC/DONE are ignored.
        m_r0    = 4;
        m_count = (m_count + 1) % 4;
        issue(3'b010, 5'd4, m_r0, m_count, 1'b1);
        step();
        check("noise_no_accept", 32'(bus.busy), 32'd0);
        check("noise_r0", 32'(bus.r0_out), 32'd4);

        // Reset during EXEC aborts the instruction.
        bus.start   = 1'b1;
        bus.instr   = 3'b010;
        bus.operand = 5'd7;
        step();
        bus.start = 1'b0;
        check("abort_in_exec", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        step();
        check("abort_r0", 32'(bus.r0_out), 32'd0);
        check("abort_count", 32'(bus.count), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_data_in", 32'(bus.alu_data_in), 32'd0);
        rst = 1'b0;
        step();
        check("abort_idle_done", 32'(bus.done), 32'd0);
        check("abort_idle_busy", 32'(bus.busy), 32'd0);
        m_r0    = 0;
        m_count = 0;

        // Reset during DONE clears the pulse with no repeat.
        m_r0    = 9;
        bus.start   = 1'b1;
        bus.instr   = 3'b010;
        bus.operand = 5'd9;
        step();
        bus.start = 1'b0;
        step();
        check("rdone_pulse", 32'(bus.done), 32'd1);
        check("rdone_r0", 32'(bus.r0_out), 32'd9);
        rst = 1'b1;
        step();
        check("rdone_cleared", 32'(bus.done), 32'd0);
        check("rdone_r0_rst", 32'(bus.r0_out), 32'd0);
        rst = 1'b0;
        step();
        check("rdone_no_repeat", 32'(bus.done), 32'd0);
        m_r0    = 0;
        m_count = 0;

        // Randomized instructions with idle gaps; Instr/Operand wander
        // while Start is low and must not matter.
        for (int n = 0; n < 40; n++) begin
            op  = int'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 31));
            exp = alu_eval(op, d, m_r0, m_count);
            m_r0    = exp;
            m_count = (m_count + 1) % 4;
            issue(3'(op), 5'(d), m_r0, m_count, 1'($urandom_range(0, 1)));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                bus.instr   = 3'($urandom_range(0, 7));
                bus.operand = 5'($urandom_range(0, 31));
                step();
                check("gap_idle", 32'(bus.busy), 32'd0);
                check("gap_r0", 32'(bus.r0_out), 32'(m_r0));
                check("gap_count", 32'(bus.count), 32'(m_count));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_controller.md
ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 SHALL have no parameters; all widths fixed (data 5 b, opcode 3 b, count 2 b).
REQ-002 Clock  input  1  single rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to execute one instruction; sampled only in IDLE.
REQ-005 Instr  input  3  ALU opcode for the requested instruction.
REQ-006 Operand  input  5  data operand for the requested instruction.
REQ-007 ALUResult  input  5  combinational result returned by the ALU.
REQ-008 ALU_OP  output  3  opcode driven to the ALU.
REQ-009 ALUDataIn  output  5  registered operand driven to the ALU data input.
REQ-010 R0Out  output  5  accumulator R0, driven to the ALU R0 input and observable.
REQ-011 Count  output  2  completed-instruction counter, driven to the ALU counter input.
REQ-012 Busy  output  1  high in EXEC and DONE.
REQ-013 Done  output  1  one-cycle completion pulse.
REQ-014 Zero  output  1  R0 == 0 flag; present only per REQ-032.

Function
REQ-015 FSM states SHALL be IDLE, EXEC and DONE; encoding is free.
REQ-016 IDLE with Start=1 SHALL capture Instr and Operand into internal registers and go to EXEC; with Start=0 it stays in IDLE.
REQ-017 EXEC SHALL last exactly one cycle: ALU_OP = captured opcode, ALUDataIn = captured operand, R0 <= ALUResult at the closing edge, then go to DONE.
REQ-018 DONE SHALL last exactly one cycle with Done=1, then return to IDLE.
REQ-019 Count SHALL increment by 1 at the EXEC->DONE edge and wrap 3->0; it is unchanged in all other cycles.
REQ-020 Latency: Start accepted at edge N -> R0 updated at edge N+1 -> Done high during cycle N+1..N+2 -> IDLE at edge N+2; minimum issue interval 3 cycles.
REQ-021 Opcode 000 SHALL see the pre-increment Count (R0 receives the number of instructions completed before it, mod 4).
REQ-022 In IDLE and DONE, ALU_OP SHALL be 3'b011 (R0 pass-through) and ALUDataIn SHALL hold its last captured value; R0 is not written.
REQ-023 Start in EXEC or DONE SHALL be ignored and not queued; Start held high continuously SHALL be accepted on each IDLE cycle.
REQ-024 ALUResult SHALL be taken as-is (5-bit, modulo 32); the controller performs no arithmetic on it.
REQ-025 Instr and Operand changes outside the IDLE capture edge SHALL have no effect.

Reset
REQ-026 Reset=1 at a rising edge SHALL force state IDLE, R0=0, Count=0, captured opcode=3'b011, captured operand=0.
REQ-027 Outputs during/after reset: ALU_OP=3'b011, ALUDataIn=0, R0Out=0, Count=0, Busy=0, Done=0, Zero=1 (if built).
REQ-028 Reset SHALL take priority over Start and over any state transition.
REQ-029 Reset in EXEC SHALL abort: R0 not written from ALUResult, Count not incremented, no Done pulse.
REQ-030 Reset in DONE SHALL clear Done on the following cycle; no second pulse follows.

Configuration
REQ-031 Macro ALU_CONTROLLER_ZERO_FLAG_EN SHALL control the Zero feature.
REQ-032 Defined: Zero port exists, registered, updated with R0 (Zero=1 iff R0==0 after each R0 write or reset). Undefined: Zero port and its logic are absent; all other behaviour identical.

Verification
REQ-033 Reset 2 cycles, Start=0 -> R0Out=0, Count=0, Busy=0, Done=0, ALU_OP=3'b011, Zero=1.
REQ-034 Start, Instr=010, Operand=5 at edge N -> ALU_OP=010 in cycle N..N+1, R0Out=5 after N+1, Done=1 only in cycle N+1..N+2, Count=1.
REQ-035 Then Instr=100, Operand=3 -> R0=8; then Instr=101, Operand=8 -> R0=0, Zero=1 (macro defined), Count=3.
REQ-036 Fourth instruction Instr=000 -> R0=3, Count wraps to 0; fifth Instr=000 -> R0=0.
REQ-037 Start held high for 9 cycles from IDLE -> exactly 3 instructions, Done every 3rd cycle; Start pulses in EXEC/DONE with Instr=111 -> ignored, R0 unchanged.
REQ-038 Reset asserted during EXEC of Instr=010, Operand=7 -> R0=0, Count=0, no Done, IDLE next cycle.
